// File: rtl/ea_sequencer_6801_if.sv
// Operand-bus bundle between the 6801 effective-address sequencer and its neighbours.
// Optional macro EA_MODE_ERR_EN adds the mode_err flag to the bundle.
interface ea_sequencer_6801_if;
  logic        hold;
  logic        start;
  logic [2:0]  mode;
  logic [2:0]  vec_sel;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [15:0] x_reg;
  logic        ea_inc;
  logic [15:0] ea;
  logic        ea_valid;
  logic        busy;
  logic        fetch_req;
`ifdef EA_MODE_ERR_EN
  logic        mode_err;

  modport master (
    output hold, start, mode, vec_sel, data_in, data_valid, x_reg, ea_inc,
    input  ea, ea_valid, busy, fetch_req, mode_err
  );

  modport slave (
    input  hold, start, mode, vec_sel, data_in, data_valid, x_reg, ea_inc,
    output ea, ea_valid, busy, fetch_req, mode_err
  );
`else
  modport master (
    output hold, start, mode, vec_sel, data_in, data_valid, x_reg, ea_inc,
    input  ea, ea_valid, busy, fetch_req
  );

  modport slave (
    input  hold, start, mode, vec_sel, data_in, data_valid, x_reg, ea_inc,
    output ea, ea_valid, busy, fetch_req
  );
`endif
endinterface

// File: rtl/ea_sequencer_6801.sv
// Effective-address sequencer feeding the 6801 program counter and operand path.
// Optional macro EA_MODE_ERR_EN: adds mode_err, pulsed with ea_valid for reserved modes 5-7.
module ea_sequencer_6801 #(
  parameter logic [7:0]  DIRECT_PAGE = 8'h00,
  parameter logic [15:0] VECTOR_BASE = 16'hFFF0
) (
  input logic                clk,
  input logic                reset,
  ea_sequencer_6801_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_HI = 3'd1,
    S_FETCH_LO = 3'd2,
    S_CALC     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [2:0] M_DIRECT   = 3'd0;
  localparam logic [2:0] M_EXTENDED = 3'd1;
  localparam logic [2:0] M_INDEXED  = 3'd2;
  localparam logic [2:0] M_RELATIVE = 3'd3;
  localparam logic [2:0] M_VECTOR   = 3'd4;

  state_t      r_state;
  state_t      w_nxt;
  logic [2:0]  r_mode;
  logic [15:0] r_ea;
  logic        r_ea_valid;
  logic        r_busy;
  logic        r_fetch_req;
`ifdef EA_MODE_ERR_EN
  logic        r_mode_err;
`endif

  // Reserved modes fold onto the last vector slot.
  function automatic logic [15:0] vector_addr(input logic [2:0] mode, input logic [2:0] sel);
    logic [2:0] slot;
    slot = (mode > M_VECTOR) ? 3'd7 : sel;
    return VECTOR_BASE | {12'h000, slot, 1'b0};
  endfunction

  function automatic logic [15:0] sign_ext8(input logic [7:0] b);
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    s8  = signed'(b);
    s16 = 16'(s8);
    return unsigned'(s16);
  endfunction

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.mode)
            M_EXTENDED:                       w_nxt = S_FETCH_HI;
            M_DIRECT, M_INDEXED, M_RELATIVE:  w_nxt = S_FETCH_LO;
            default:                          w_nxt = S_DONE;
          endcase
        end
      end
      S_FETCH_HI: if (bus.data_valid) w_nxt = S_FETCH_LO;
      S_FETCH_LO: if (bus.data_valid) w_nxt = (r_mode == M_INDEXED) ? S_CALC : S_DONE;
      S_CALC:     w_nxt = S_DONE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they are pure functions of r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 3'd0;
      r_ea        <= 16'h0000;
      r_ea_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_fetch_req <= 1'b0;
`ifdef EA_MODE_ERR_EN
      r_mode_err  <= 1'b0;
`endif
    end else if (!bus.hold) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            if (bus.mode > M_RELATIVE)
              r_ea <= vector_addr(bus.mode, bus.vec_sel);
          end else if (bus.ea_inc) begin
            r_ea <= r_ea + 16'd1;
          end
        end
        S_FETCH_HI: begin
          if (bus.data_valid) r_ea[15:8] <= bus.data_in;
        end
        S_FETCH_LO: begin
          if (bus.data_valid) begin
            case (r_mode)
              M_DIRECT:   r_ea      <= {DIRECT_PAGE, bus.data_in};
              M_EXTENDED: r_ea[7:0] <= bus.data_in;
              M_RELATIVE: r_ea      <= sign_ext8(bus.data_in);
              default:    r_ea      <= {8'h00, bus.data_in};
            endcase
          end
        end
        S_CALC: begin
          r_ea <= bus.x_reg + r_ea;
        end
        default: begin
        end
      endcase
      r_state     <= w_nxt;
      r_busy      <= (w_nxt != S_IDLE);
      r_fetch_req <= (w_nxt == S_FETCH_HI) || (w_nxt == S_FETCH_LO);
      r_ea_valid  <= (w_nxt == S_DONE);
`ifdef EA_MODE_ERR_EN
      r_mode_err  <= (r_state == S_IDLE) && bus.start && (bus.mode > M_VECTOR);
`endif
    end
  end

  assign bus.ea        = r_ea;
  assign bus.ea_valid  = r_ea_valid;
  assign bus.busy      = r_busy;
  assign bus.fetch_req = r_fetch_req;
`ifdef EA_MODE_ERR_EN
  assign bus.mode_err  = r_mode_err;
`endif

endmodule
